// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: central PCI REQ#/GNT# arbiter with round-robin selection,
// bus parking, hidden arbitration and a grant-to-FRAME timeout.
// GNT, owner, bus_busy and timeout_evt are all registered.
module pci_bus_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int TIMEOUT      = 16,
    parameter int PARK_DEFAULT = 0
) (
    input  logic                           clk,
    input  logic                           RST,
    input  logic [NUM_MASTERS-1:0]         REQ,
    output logic [NUM_MASTERS-1:0]         GNT,
    input  logic                           FRAME,
    input  logic                           IRDY,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic                           bus_busy,
    output logic                           timeout_evt
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [OW-1:0] PARK_IDX   = OW'(PARK_DEFAULT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {PARK, GAP, GRANT, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          rr_q, rr_d;
    logic [OW-1:0]          next_q, next_d;
    logic                   next_vld_q, next_vld_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic                   busy_q, busy_d;
    logic                   tevt_q, tevt_d;

    logic                   bus_idle;
    logic                   any_req;
    logic                   win_all_vld, win_oth_vld;
    logic [OW-1:0]          win_all, win_oth;

    // Round-robin scan of active-low requests starting after 'start';
    // optionally skips 'excl'. Returns {found, index}.
    function automatic logic [OW:0] pick(input logic [NUM_MASTERS-1:0] req_n,
                                         input logic [OW-1:0]          start,
                                         input logic                   excl_en,
                                         input logic [OW-1:0]          excl);
        logic [OW:0] res;
        int unsigned idx;
        res = '0;
        for (int unsigned i = 1; i <= unsigned'(NUM_MASTERS); i++) begin
            idx = (32'(start) + i) % unsigned'(NUM_MASTERS);
            if (!res[OW] && !req_n[OW'(idx)] && !(excl_en && (OW'(idx) == excl)))
                res = {1'b1, OW'(idx)};
        end
        return res;
    endfunction

    assign bus_idle = FRAME & IRDY;
    assign any_req  = ~&REQ;

    // Candidate winners: one over all requesters, one excluding the owner.
    always_comb begin
        {win_all_vld, win_all} = pick(REQ, rr_q, 1'b0, owner_q);
        {win_oth_vld, win_oth} = pick(REQ, rr_q, 1'b1, owner_q);
    end

    // State register and arbitration bookkeeping.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= PARK;
            owner_q    <= PARK_IDX;
            rr_q       <= PARK_IDX;
            next_q     <= PARK_IDX;
            next_vld_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            next_q     <= next_d;
            next_vld_q <= next_vld_d;
            timer_q    <= timer_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        next_d     = next_q;
        next_vld_d = next_vld_q;
        timer_d    = timer_q;
        tevt_d     = 1'b0;
        unique case (state_q)
            PARK: begin
                if (win_all_vld) begin
                    if (win_all == owner_q) begin
                        state_d = GRANT;
                        timer_d = '0;
                        rr_d    = owner_q;
                    end else begin
                        state_d    = GAP;
                        next_d     = win_all;
                        next_vld_d = 1'b1;
                    end
                end
            end
            GAP: begin
                next_vld_d = 1'b0;
                if (next_vld_q && any_req) begin
                    state_d = GRANT;
                    owner_d = next_q;
                    rr_d    = next_q;
                    timer_d = '0;
                end else begin
                    state_d = PARK;
                end
            end
            GRANT: begin
                // FRAME is checked first so it wins over REQ release and timeout.
                if (!FRAME && !busy_q) begin
                    state_d = BUSY;
                    timer_d = '0;
                end else if (REQ[owner_q]) begin
                    if (win_oth_vld) begin
                        state_d    = GAP;
                        next_d     = win_oth;
                        next_vld_d = 1'b1;
                    end else begin
                        state_d = PARK;
                    end
                end else if (bus_idle) begin
                    if (timer_q == TIMER_LAST) begin
                        tevt_d     = 1'b1;
                        rr_d       = owner_q;
                        state_d    = GAP;
                        next_d     = win_oth;
                        next_vld_d = win_oth_vld;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            BUSY: begin
                if (win_oth_vld) begin
                    state_d    = GAP;
                    next_d     = win_oth;
                    next_vld_d = 1'b1;
                end else if (bus_idle) begin
                    state_d = PARK;
                end
            end
            default: state_d = PARK;
        endcase
    end

    // Output decode from the state being entered, so outputs register with it.
    always_comb begin
        gnt_d = '1;
        if (state_d != GAP)
            gnt_d[owner_d] = 1'b0;
        busy_d = ~bus_idle;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            gnt_q  <= '1;
            busy_q <= 1'b0;
            tevt_q <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            busy_q <= busy_d;
            tevt_q <= tevt_d;
        end
    end

    assign GNT         = gnt_q;
    assign owner       = owner_q;
    assign bus_busy    = busy_q;
    assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb_pci_bus_arbiter: directed stimulus with a per-cycle behavioural model
// plus hand-computed literal expectations at key points.
module tb_pci_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int PD = 0;

    logic       clk;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       FRAME;
    logic       IRDY;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout_evt;

    int n_checks = 0;
    int n_pass   = 0;

    pci_bus_arbiter #(
        .NUM_MASTERS  (N),
        .TIMEOUT      (TO),
        .PARK_DEFAULT (PD)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .REQ         (REQ),
        .GNT         (GNT),
        .FRAME       (FRAME),
        .IRDY        (IRDY),
        .owner       (owner),
        .bus_busy    (bus_busy),
        .timeout_evt (timeout_evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Who holds the grant, whether a handover gap is in progress, and whether
    // the holder is parked, waiting for FRAME, or running a transaction.
    int m_owner, m_rr, m_pending, m_timer;
    bit m_gap, m_parked, m_txn, m_prev_idle, m_rst, m_valid, e_tevt;

    function automatic int scan(input logic [3:0] req, input int from, input int skip);
        for (int k = 1; k <= N; k++) begin
            int m;
            m = (from + k) % N;
            if (m != skip && req[m] == 1'b0) return m;
        end
        return -1;
    endfunction

    task automatic go_gap(input int who);
        m_gap = 1; m_pending = who; m_parked = 0; m_txn = 0;
    endtask

    task automatic model_step(input logic [3:0] req, input logic frame, input logic irdy, input logic rst);
        bit idle;
        int w_all, w_oth;
        idle   = frame && irdy;
        e_tevt = 0;
        if (rst) begin
            m_valid = 1; m_rst = 1; m_owner = PD; m_rr = PD; m_pending = -1;
            m_gap = 0; m_parked = 1; m_txn = 0; m_timer = 0; m_prev_idle = 1;
            return;
        end
        m_rst = 0;
        w_all = scan(req, m_rr, -1);
        w_oth = scan(req, m_rr, m_owner);
        if (m_gap) begin
            m_gap = 0;
            if (m_pending >= 0 && req != 4'hF) begin
                m_owner = m_pending; m_rr = m_pending; m_timer = 0;
                m_parked = 0; m_txn = 0;
            end else begin
                m_parked = 1;
            end
            m_pending = -1;
        end else if (m_parked) begin
            if (w_all == m_owner) begin
                m_parked = 0; m_timer = 0; m_rr = m_owner;
            end else if (w_all >= 0) begin
                go_gap(w_all);
            end
        end else if (m_txn) begin
            if (w_oth >= 0) go_gap(w_oth);
            else if (idle) begin m_txn = 0; m_parked = 1; end
        end else begin
            if (!frame && m_prev_idle) begin
                m_txn = 1; m_timer = 0;
            end else if (req[m_owner]) begin
                if (w_oth >= 0) go_gap(w_oth);
                else m_parked = 1;
            end else if (idle) begin
                if (m_timer == TO - 1) begin
                    e_tevt = 1; m_rr = m_owner; go_gap(w_oth);
                end else begin
                    m_timer++;
                end
            end
        end
        m_prev_idle = idle;
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        logic [3:0] exp_gnt;
        model_step(REQ, FRAME, IRDY, RST);
        #1;
        if (m_valid) begin
            exp_gnt = (m_rst || m_gap) ? 4'hF : ~(4'b0001 << m_owner);
            chk("m_gnt", 32'(GNT), 32'(exp_gnt));
            chk("m_owner", 32'(owner), 32'(m_owner));
            chk("m_busy", 32'(bus_busy), 32'(m_rst ? 1'b0 : !m_prev_idle));
            chk("m_tevt", 32'(timeout_evt), 32'(e_tevt));
            chk("gnt_onehot", 32'($countones(~GNT) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int cnt, tcnt;
        bit found;
        RST = 1'b1; REQ = 4'hF; FRAME = 1'b1; IRDY = 1'b1;
        repeat (3) tick();
        chk("rst_gnt", 32'(GNT), 32'hF);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(bus_busy), 32'd0);
        chk("rst_tevt", 32'(timeout_evt), 32'd0);

        // Reset release, parked on master 0.
        RST = 1'b0; tick();
        chk("rel_gnt", 32'(GNT), 32'hE);
        chk("rel_owner", 32'(owner), 32'd0);

        // Master 2 requests while parked on 0.
        REQ = 4'b1011; tick();
        chk("t2_gap", 32'(GNT), 32'hF);
        tick();
        chk("t2_gnt", 32'(GNT), 32'hB);
        chk("t2_owner", 32'(owner), 32'd2);
        FRAME = 1'b0; tick();
        chk("t2_busy", 32'(bus_busy), 32'd1);
        IRDY = 1'b0; tick();
        FRAME = 1'b1; tick();
        IRDY = 1'b1; REQ = 4'hF; tick();
        chk("t2_park", 32'(GNT), 32'hB);

        // Make master 1 the last owner, then 0 and 2 request together.
        REQ = 4'b1101; tick(); tick();
        REQ = 4'hF; tick();
        chk("t3_park1", 32'(owner), 32'd1);
        REQ = 4'b1010; tick(); tick();
        chk("t3_first", 32'(GNT), 32'hB);
        FRAME = 1'b0; IRDY = 1'b0; REQ = 4'b1110; tick();
        tick();
        chk("t3_gap", 32'(GNT), 32'hF);
        tick();
        chk("t3_second", 32'(GNT), 32'hE);
        FRAME = 1'b1; tick();
        IRDY = 1'b1; tick();
        FRAME = 1'b0; IRDY = 1'b0; tick();
        REQ = 4'hF; FRAME = 1'b1; tick();
        IRDY = 1'b1; tick();

        // Timeout of master 3 with no other requester.
        REQ = 4'b0111; tick(); tick();
        chk("t4_gnt", 32'(GNT), 32'h7);
        cnt = 1; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (timeout_evt) found = 1;
            else if (GNT == 4'b0111) cnt++;
        end
        chk("t4_seen", 32'(found), 32'd1);
        chk("t4_cycles", 32'(cnt), 32'd16);
        chk("t4_gap", 32'(GNT), 32'hF);
        REQ = 4'hF; tick();
        chk("t4_park", 32'(GNT), 32'h7);
        chk("t4_pulse_end", 32'(timeout_evt), 32'd0);

        // Timeout of master 3 with master 1 waiting.
        REQ = 4'b0111; tick();
        REQ = 4'b0101;
        found = 0; tcnt = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (timeout_evt) tcnt++;
            if (GNT == 4'b1101) found = 1;
        end
        chk("t4b_next", 32'(found), 32'd1);
        chk("t4b_pulses", 32'(tcnt), 32'd1);

        // Hidden arbitration while master 1 is busy.
        REQ = 4'b1101; FRAME = 1'b0; IRDY = 1'b0; tick();
        REQ = 4'b1001; tick();
        chk("t5_gap", 32'(GNT), 32'hF);
        tick();
        chk("t5_gnt", 32'(GNT), 32'hB);
        REQ = 4'b1010;
        tcnt = 0; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (timeout_evt) tcnt++;
            if (GNT == 4'b1011) cnt++;
        end
        chk("t5_no_timeout", 32'(tcnt), 32'd0);
        chk("t5_held", 32'(cnt), 32'd20);
        FRAME = 1'b1; tick();
        FRAME = 1'b0; IRDY = 1'b1; tick();
        chk("t5_not_taken", 32'(GNT), 32'hB);
        FRAME = 1'b1; tick();
        FRAME = 1'b0; IRDY = 1'b0; tick();
        chk("t5_taken_gnt", 32'(GNT), 32'hB);
        tick();
        chk("t5_hidden_gap", 32'(GNT), 32'hF);
        tick();
        chk("t5_gnt0", 32'(GNT), 32'hE);

        // Reset in the middle of a master 3 transaction.
        REQ = 4'b0111; FRAME = 1'b1; IRDY = 1'b1; tick(); tick();
        chk("t6_gnt3", 32'(GNT), 32'h7);
        FRAME = 1'b0; IRDY = 1'b0; tick();
        RST = 1'b1; tick();
        chk("t6_rst_gnt", 32'(GNT), 32'hF);
        chk("t6_rst_owner", 32'(owner), 32'd0);
        chk("t6_rst_busy", 32'(bus_busy), 32'd0);
        RST = 1'b0; REQ = 4'hF; FRAME = 1'b1; IRDY = 1'b1; tick();
        chk("t6_park", 32'(GNT), 32'hE);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
